// File: rtl/tthbif_cfg_rf.sv
// HBIF configuration register file driven by a byte-oriented UART command protocol.
// Optional WAIT_DATA timeout is built only when TTHBIF_CFG_RF_TIMEOUT_EN is defined.
module tthbif_cfg_rf #(
  parameter int NUM_LANES      = 1,
  parameter int TIMEOUT_CYCLES = 700000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rx_data_valid_i,
  input  logic [7:0]             rx_data_i,
  input  logic                   tx_data_ready_i,
  output logic                   tx_data_valid_o,
  output logic [7:0]             tx_data_o,
  output logic                   lane_en_o,
  output logic [2*NUM_LANES-1:0] comb_tap_sel_o,
  output logic [2*NUM_LANES-1:0] flop_tap_sel_o
);

  if (NUM_LANES < 1 || NUM_LANES > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("tthbif_cfg_rf: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, WAIT_DATA, SEND} state_t;

  state_t                 state, state_next;
  logic [7:0]             tx_data;
  logic [2:0]             status;
  logic                   lane_en;
  logic [2*NUM_LANES-1:0] comb_sel, flop_sel;
  logic [3:0]             wr_addr;
  logic                   wr_bad;

  logic [3:0]             cmd_addr;
  logic                   lane_hit;
  logic                   cmd_bad;
  logic [7:0]             rd_data;
  logic [2:0]             status_set;
  logic [2:0]             status_clr;
  logic                   wr_en;
  logic                   resp_load;
  logic                   cmd_latch;
  logic                   timeout_hit;

  assign cmd_addr = rx_data_i[3:0];

  // Decode and read mux operate on the incoming command byte.
  always_comb begin
    lane_hit = 1'b0;
    rd_data  = 8'h00;
    for (int n = 0; n < NUM_LANES; n++) begin
      if (cmd_addr == 4'(4 + n)) begin
        lane_hit = 1'b1;
        rd_data  = {4'b0000, flop_sel[2*n +: 2], comb_sel[2*n +: 2]};
      end
    end
    case (cmd_addr)
      4'h0:    rd_data = 8'hB1;
      4'h1:    rd_data = {5'b00000, status};
      4'h2:    rd_data = {7'b0000000, lane_en};
      default: ;
    endcase
    cmd_bad = (rx_data_i[6:4] != 3'b000) || !(cmd_addr <= 4'h2 || lane_hit);
    if (cmd_bad) begin
      rd_data = 8'h00;
    end
  end

`ifdef TTHBIF_CFG_RF_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign timeout_hit = (state == WAIT_DATA) && (cnt == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || state != WAIT_DATA) begin
      cnt <= '0;
    end else if (cnt != CNT_LAST) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    status_set = 3'b000;
    wr_en      = 1'b0;
    resp_load  = 1'b0;
    cmd_latch  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_data_valid_i) begin
          if (rx_data_i[7]) begin
            state_next = WAIT_DATA;
            cmd_latch  = 1'b1;
            // ID is read-only, so a write to it counts as a bad command.
            status_set[2] = cmd_bad || (cmd_addr == 4'h0);
          end else begin
            state_next    = SEND;
            resp_load     = 1'b1;
            status_set[2] = cmd_bad;
          end
        end
      end
      WAIT_DATA: begin
        if (rx_data_valid_i) begin
          state_next = IDLE;
          wr_en      = !wr_bad;
        end else if (timeout_hit) begin
          state_next    = IDLE;
          status_set[1] = 1'b1;
        end
      end
      SEND: begin
        status_set[0] = rx_data_valid_i;
        if (tx_data_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    status_clr = (wr_en && wr_addr == 4'h1) ? rx_data_i[2:0] : 3'b000;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      tx_data  <= 8'h00;
      status   <= 3'b000;
      lane_en  <= 1'b0;
      comb_sel <= '1;
      flop_sel <= '1;
      wr_addr  <= 4'h0;
      wr_bad   <= 1'b0;
    end else begin
      state  <= state_next;
      // Set events take priority over a simultaneous W1C clear.
      status <= (status & ~status_clr) | status_set;
      if (resp_load) begin
        tx_data <= rd_data;
      end
      if (cmd_latch) begin
        wr_addr <= cmd_addr;
        wr_bad  <= cmd_bad || (cmd_addr == 4'h0);
      end
      if (wr_en && wr_addr == 4'h2) begin
        lane_en <= rx_data_i[0];
      end
      for (int n = 0; n < NUM_LANES; n++) begin
        if (wr_en && wr_addr == 4'(4 + n)) begin
          comb_sel[2*n +: 2] <= rx_data_i[1:0];
          flop_sel[2*n +: 2] <= rx_data_i[3:2];
        end
      end
    end
  end

  assign tx_data_valid_o = (state == SEND);
  assign tx_data_o       = tx_data;
  assign lane_en_o       = lane_en;
  assign comb_tap_sel_o  = comb_sel;
  assign flop_tap_sel_o  = flop_sel;

endmodule

// File: tb/tb_tthbif_cfg_rf.sv
// Directed testbench for tthbif_cfg_rf; response bytes are checked through a scoreboard queue.
// Timeout checks follow the TTHBIF_CFG_RF_TIMEOUT_EN build option.
module tb_tthbif_cfg_rf;

  localparam int NL = 2;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_ready = 1'b1;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          lane_en;
  logic [2*NL-1:0] comb_sel, flop_sel;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  tthbif_cfg_rf #(.NUM_LANES(NL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rx_data_valid_i(rx_valid),
    .rx_data_i      (rx_data),
    .tx_data_ready_i(tx_ready),
    .tx_data_valid_o(tx_valid),
    .tx_data_o      (tx_data),
    .lane_en_o      (lane_en),
    .comb_tap_sel_o (comb_sel),
    .flop_tap_sel_o (flop_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the byte is captured at the following posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic write_reg(input logic [7:0] cmd, input logic [7:0] data);
    send_byte(cmd);
    send_byte(data);
  endtask

  task automatic collect(input string tag);
    int n = 0;
    logic [7:0] exp;
    while (!(tx_valid && tx_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
    if (n >= 50) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check(tag, {24'h0, tx_data}, {24'h0, exp});
      @(negedge clk);
      check({tag, "_done"}, {31'h0, tx_valid}, 32'd0);
    end
  endtask

  task automatic read_reg(input string tag, input logic [7:0] cmd, input logic [7:0] exp);
    exp_q.push_back(exp);
    send_byte(cmd);
    collect(tag);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", {31'h0, tx_valid}, 32'd0);
    check("rst_data", {24'h0, tx_data}, 32'h00);
    check("rst_lane_en", {31'h0, lane_en}, 32'd0);
    check("rst_comb", {28'h0, comb_sel}, 32'hF);
    check("rst_flop", {28'h0, flop_sel}, 32'hF);

    read_reg("read_id", 8'h00, 8'hB1);

    write_reg(8'h84, 8'h06);
    check("lane0_comb", {30'h0, comb_sel[1:0]}, 32'h2);
    check("lane0_flop", {30'h0, flop_sel[1:0]}, 32'h1);
    check("lane1_untouched", {28'h0, comb_sel[3:2], flop_sel[3:2]}, 32'hF);
    read_reg("read_lane0", 8'h04, 8'h06);
    write_reg(8'h85, 8'hFB);
    check("lane1_comb", {30'h0, comb_sel[3:2]}, 32'h3);
    check("lane1_flop", {30'h0, flop_sel[3:2]}, 32'h2);
    read_reg("read_lane1", 8'h05, 8'h0B);

    write_reg(8'h82, 8'hFF);
    check("ctrl_set", {31'h0, lane_en}, 32'd1);
    read_reg("read_ctrl", 8'h02, 8'h01);

    // Hold the response while the transmitter is busy and inject an overrun byte.
    exp_q.push_back(8'h00);
    tx_ready = 1'b0;
    send_byte(8'h01);
    for (int i = 0; i < 10; i++) begin
      rx_valid = (i == 3);
      rx_data  = 8'h55;
      @(negedge clk);
      check("hold_valid", {31'h0, tx_valid}, 32'd1);
      check("hold_data", {24'h0, tx_data}, {24'h0, exp_q[0]});
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    collect("held_resp");
    read_reg("overrun", 8'h01, 8'h01);
    write_reg(8'h81, 8'h01);
    read_reg("overrun_clr", 8'h01, 8'h00);

`ifdef TTHBIF_CFG_RF_TIMEOUT_EN
    send_byte(8'h82);
    repeat (TO) @(negedge clk);
    check("to_ctrl_kept", {31'h0, lane_en}, 32'd1);
    read_reg("to_status", 8'h01, 8'h02);
    write_reg(8'h81, 8'h02);
    read_reg("to_clr", 8'h01, 8'h00);
    send_byte(8'h82);
    repeat (TO - 2) @(negedge clk);
    send_byte(8'h00);
    check("to_edge_write", {31'h0, lane_en}, 32'd0);
    read_reg("to_edge_status", 8'h01, 8'h00);
`else
    send_byte(8'h82);
    repeat (2 * TO) @(negedge clk);
    check("wait_ctrl_kept", {31'h0, lane_en}, 32'd1);
    send_byte(8'h00);
    check("late_write", {31'h0, lane_en}, 32'd0);
    read_reg("no_to_status", 8'h01, 8'h00);
`endif

    read_reg("bad_addr", 8'h0F, 8'h00);
    read_reg("bad_bits", 8'h70, 8'h00);
    read_reg("bad_status", 8'h01, 8'h04);
    write_reg(8'h81, 8'h04);
    read_reg("bad_clr", 8'h01, 8'h00);
    write_reg(8'h80, 8'h12);
    read_reg("id_write_status", 8'h01, 8'h04);
    read_reg("id_kept", 8'h00, 8'hB1);
    write_reg(8'h81, 8'h04);
    write_reg(8'h86, 8'h00);
    check("bad_lane_ignored", {28'h0, comb_sel[3:2], flop_sel[3:2]}, 32'hE);
    read_reg("bad_lane_status", 8'h01, 8'h04);
    write_reg(8'h81, 8'h04);

    send_byte(8'h82);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid", {31'h0, tx_valid}, 32'd0);
    read_reg("abort_resp", 8'h01, 8'h00);
    check("abort_lane_en", {31'h0, lane_en}, 32'd0);
    check("abort_lanes", {28'h0, comb_sel}, 32'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tthbif_cfg_rf.md
TTHBIF_CFG_RF -- requirements
Module: tthbif_cfg_rf

Interface
REQ-001 Parameter NUM_LANES, default 1, number of HBIF lanes configured; legal range 1..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 700000, clock cycles allowed between command byte and write-data byte.
REQ-003 clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 rx_data_valid_i  input  1  one-cycle strobe from the UART receiver marking a received byte.
REQ-006 rx_data_i  input  8  received byte, qualified by rx_data_valid_i.
REQ-007 tx_data_ready_i  input  1  UART transmitter can accept a byte.
REQ-008 tx_data_valid_o  output  1  response byte valid.
REQ-009 tx_data_o  output  8  response byte.
REQ-010 lane_en_o  output  1  lane enable, CTRL[0].
REQ-011 comb_tap_sel_o  output  2*NUM_LANES  per-lane comb tap select; lane n at bits [2n+1:2n].
REQ-012 flop_tap_sel_o  output  2*NUM_LANES  per-lane flop tap select; lane n at bits [2n+1:2n].

Function
REQ-013 Command byte: bit7=1 write, 0 read; bits[6:4] must be 0; bits[3:0] address.
REQ-014 Register map: 0x0 ID, RO, 0xB1; 0x1 STATUS, W1C; 0x2 CTRL, RW bit0 only; 0x4+n LANE n, RW: bits[1:0] comb sel, bits[3:2] flop sel, for n<NUM_LANES.
REQ-015 Unimplemented bits read 0; writes to them are ignored.
REQ-016 STATUS bits: bit0 overrun, bit1 timeout, bit2 bad command; all sticky.
REQ-017 Bad command = nonzero bits[6:4], or address not in the map; such reads return 0x00, writes are discarded, bit2 set.
REQ-018 FSM states IDLE, WAIT_DATA, SEND.
REQ-019 IDLE + byte with bit7=0 -> SEND; tx_data_o = register value, tx_data_valid_o=1 on the next cycle.
REQ-020 IDLE + byte with bit7=1 -> WAIT_DATA; address latched, timeout counter cleared.
REQ-021 WAIT_DATA + byte -> register written at the clock edge after the data-byte strobe; outputs reflect the write on that cycle; -> IDLE; no response byte.
REQ-022 SEND: tx_data_valid_o and tx_data_o held stable until tx_data_ready_i=1; transfer on a cycle where both are 1; -> IDLE next cycle with valid deasserted.
REQ-023 Write to ID is treated as a bad command.
REQ-024 Byte received in SEND is dropped and sets STATUS bit0.
REQ-025 WAIT_DATA counter reaches TIMEOUT_CYCLES-1 with no byte -> IDLE, STATUS bit1 set, pending write discarded.
REQ-026 Data byte arriving on the same cycle the timeout expires is accepted; no timeout is flagged.
REQ-027 STATUS write clears the bits written as 1; a set event in the same cycle wins over the clear.
REQ-028 Timeout counter width = $clog2(TIMEOUT_CYCLES); the counter never wraps.

Reset
REQ-029 rst_i=1 forces IDLE, tx_data_valid_o=0, tx_data_o=0x00, STATUS=0, lane_en_o=0, every comb/flop select = 2'b11, counter=0.
REQ-030 Reset mid-transaction aborts it; no partial write is committed and no response byte is sent after reset.

Configuration
REQ-031 Macro TTHBIF_CFG_RF_TIMEOUT_EN: when defined, REQ-025/026/028 and STATUS bit1 are implemented.
REQ-032 When TTHBIF_CFG_RF_TIMEOUT_EN is undefined: no counter, WAIT_DATA waits indefinitely, STATUS bit1 reads 0.

Verification
REQ-033 After reset, send 0x00, tx_data_ready_i=1 -> one response 0xB1; comb_tap_sel_o and flop_tap_sel_o all ones; lane_en_o=0.
REQ-034 Send 0x84,0x06 then 0x04 -> response 0x06; comb_tap_sel_o[1:0]=2'b10, flop_tap_sel_o[1:0]=2'b01.
REQ-035 Send 0x01 with tx_data_ready_i=0 for 10 cycles, and send byte 0x55 during that time -> tx_data_o held stable; after transfer, read 0x01 -> 0x01.
REQ-036 Send 0x82, then no byte for TIMEOUT_CYCLES cycles (timeout enabled) -> CTRL unchanged, read 0x01 -> 0x02; send 0x81,0x02 then read 0x01 -> 0x00.
REQ-037 Send 0x0F, then 0x70 -> both return 0x00; read 0x01 -> 0x04.
REQ-038 Send 0x82, assert rst_i for 1 cycle, then send 0x01 -> lane_en_o stays 0, read response 0x00 (byte 0x01 parsed as a command).
